mem_copy_master: RTL

- Bus initiator on the picorv32 native memory interface (mem_valid / mem_ready / mem_addr / mem_wdata / mem_wstrb / mem_rdata).
- Acts as the master end of the same bus the system memory and MMIO decoder answer on.
- Copies a block of 32-bit words from a source to a destination, or fills a block with a constant, e.g. clearing a target/frame region without CPU load.
- Sits beside picorv32_core; an external arbiter selects which master owns the bus.

---
 rtl/mem_copy_master.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_copy_master.sv
// mem_copy_master
// Bus initiator on the picorv32 native memory interface. Copies a block of
// 32-bit words from src to dst (mode=0) or fills dst with a constant (mode=1).
// Every bus request is followed by at least one idle (GAP) cycle.
//
// Ports:
//   CLK, RST_BTN            clock, asynchronous active-low reset
//   start, mode             one-cycle request (IDLE only), 0=copy 1=fill
//   src_addr, dst_addr      byte addresses, bits [1:0] ignored
//   fill_data, word_count   fill word and block length, latched at start
//   abort                   stop at the next transaction boundary
//   busy, done, err         status: busy, completion pulse, sticky timeout
//   words_done              words written so far
//   mem_*                   picorv32 native memory bus (master side)
//
// state  | meaning
// IDLE   | waiting for start
// RD_REQ | read request on the bus (copy only)
// WR_REQ | write request on the bus
// GAP    | one idle bus cycle; checks abort / completion
// FINISH | done pulse, busy low, back to IDLE

module mem_copy_master #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             CLK,
    input  logic             RST_BTN,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [31:0]      fill_data,
    input  logic [CNT_W-1:0] word_count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_done,
    output logic             mem_valid,
    output logic             mem_instr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, GAP, FINISH} state_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      fill_q, fill_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] words_done_q, words_done_d;
    logic             rd_done_q, rd_done_d;
    logic             abort_q, abort_d;
    logic             err_q, err_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             mem_valid_q, mem_valid_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             hs;
    logic             timeout;
    logic             last_write;
    logic [CNT_W-1:0] wd_inc;

    // mem_valid_q is high only in RD_REQ/WR_REQ, so ready outside a request is ignored
    assign hs         = mem_valid_q && mem_ready;
    assign timeout    = (TIMEOUT_CYCLES != 0) && mem_valid_q && !mem_ready && (timer_q == '0);
    assign wd_inc     = words_done_q + CNT_W'(1);
    assign last_write = (wd_inc == count_q);

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                // a zero-length request still passes through GAP so done
                // lands two cycles after start without touching the bus
                if (start) begin
                    if (word_count == '0) state_d = GAP;
                    else if (mode)        state_d = WR_REQ;
                    else                  state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (hs)           state_d = GAP;
                else if (timeout) state_d = FINISH;
            end
            WR_REQ: begin
                if (hs)           state_d = last_write ? FINISH : GAP;
                else if (timeout) state_d = FINISH;
            end
            GAP: begin
                if (abort_q || abort || (words_done_q == count_q)) state_d = FINISH;
                else if (mode_q || rd_done_q)                      state_d = WR_REQ;
                else                                               state_d = RD_REQ;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mode_d       = mode_q;
        src_d        = src_q;
        dst_d        = dst_q;
        fill_d       = fill_q;
        data_d       = data_q;
        count_d      = count_q;
        words_done_d = words_done_q;
        rd_done_d    = rd_done_q;
        abort_d      = abort_q | abort;
        err_d        = err_q;
        timer_d      = timer_q;

        if (state_q == IDLE && start) begin
            mode_d       = mode;
            src_d        = src_addr & 32'hFFFF_FFFC;
            dst_d        = dst_addr & 32'hFFFF_FFFC;
            fill_d       = fill_data;
            count_d      = word_count;
            words_done_d = '0;
            rd_done_d    = 1'b0;
            abort_d      = 1'b0;
            err_d        = 1'b0;
        end

        if (hs && state_q == RD_REQ) begin
            data_d    = mem_rdata;
            rd_done_d = 1'b1;
        end
        if (hs && state_q == WR_REQ) begin
            src_d        = src_q + 32'd4;
            dst_d        = dst_q + 32'd4;
            words_done_d = wd_inc;
            rd_done_d    = 1'b0;
        end
        if (timeout) err_d = 1'b1;

        // reload while the bus is idle so the count starts at mem_valid rise
        if (!mem_valid_q)         timer_d = TLOAD;
        else if (timer_q != '0)   timer_d = timer_q - TW'(1);

        mem_valid_d = (state_d == RD_REQ) || (state_d == WR_REQ);
        mem_wstrb_d = (state_d == WR_REQ) ? 4'hF : 4'h0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == RD_REQ) mem_addr_d = src_d;
        if (state_d == WR_REQ) begin
            mem_addr_d  = dst_d;
            mem_wdata_d = mode_d ? fill_d : data_d;
        end
        busy_d = (state_d != IDLE) && (state_d != FINISH);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            mode_q       <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            fill_q       <= '0;
            data_q       <= '0;
            count_q      <= '0;
            words_done_q <= '0;
            rd_done_q    <= 1'b0;
            abort_q      <= 1'b0;
            err_q        <= 1'b0;
            timer_q      <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            fill_q       <= fill_d;
            data_q       <= data_d;
            count_q      <= count_d;
            words_done_q <= words_done_d;
            rd_done_q    <= rd_done_d;
            abort_q      <= abort_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_done = words_done_q;
    assign mem_valid  = mem_valid_q;
    assign mem_instr  = 1'b0;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule
